// File: rtl/seg7_scan_decoder_if.sv
// Display readback bus: scanned 7-seg inputs and decoded digit outputs.
// Master drives the display lines; slave is the decoder.
interface seg7_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic [7:0]          SEG;
  logic [DIGITS-1:0]   AN;
  logic [4*DIGITS-1:0] VALUE;
  logic [DIGITS-1:0]   DP_OUT;
  logic [DIGITS-1:0]   DIGIT_VALID;
  logic [DIGITS-1:0]   ERR;
  logic                FRAME_DONE;

  modport master (
    output SEG,
    output AN,
    input  VALUE,
    input  DP_OUT,
    input  DIGIT_VALID,
    input  ERR,
    input  FRAME_DONE
  );

  modport slave (
    input  SEG,
    input  AN,
    output VALUE,
    output DP_OUT,
    output DIGIT_VALID,
    output ERR,
    output FRAME_DONE
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Reconstructs BCD digits from a multiplexed active-low 7-seg bus,
// capturing each digit once its lines have settled.
module seg7_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int SETTLE = 4
) (
  input  logic CLK,
  input  logic RST_N,
  seg7_scan_decoder_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] LAST = 8'(SETTLE - 1);
  localparam logic [7:0] TOP  = 8'(SETTLE);

  logic [DIGITS-1:0]   r_an;
  logic [7:0]          r_seg;
  logic [7:0]          r_cnt;
  logic                r_captured;
  logic [DIGITS-1:0]   r_mask;
  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_vld;
  logic [DIGITS-1:0]   r_err;
  logic                r_frame;

  logic                w_chg;
  logic                w_an_ok;
  logic                w_cap;
  logic [IW-1:0]       w_idx;
  logic [3:0]          w_nib;
  logic                w_bad;
  logic [DIGITS-1:0]   w_hit;
  logic [DIGITS-1:0]   w_mask;

  always_comb begin
    w_chg   = ({bus.AN, bus.SEG} != {r_an, r_seg});
    w_an_ok = $onehot(~bus.AN);
    w_idx   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!r_an[i]) w_idx = IW'(i);
    end
    w_cap = !w_chg && w_an_ok && !r_captured && (r_cnt == LAST);
  end

  always_comb begin
    w_nib = 4'h0;
    w_bad = 1'b0;
    unique case (r_seg[6:0])
      7'b1000000: w_nib = 4'h0;
      7'b1111001: w_nib = 4'h1;
      7'b0100100: w_nib = 4'h2;
      7'b0110000: w_nib = 4'h3;
      7'b0011001: w_nib = 4'h4;
      7'b0010010: w_nib = 4'h5;
      7'b0000010: w_nib = 4'h6;
      7'b1111000: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0010000: w_nib = 4'h9;
      7'b1111111: w_nib = 4'hF;
      default:    w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_hit  = w_cap ? (DIGITS'(1) << w_idx) : '0;
    w_mask = r_mask | w_hit;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_an       <= '0;
      r_seg      <= '0;
      r_cnt      <= '0;
      r_captured <= 1'b0;
      r_mask     <= '0;
      r_value    <= '0;
      r_dp       <= '0;
      r_vld      <= '0;
      r_err      <= '0;
      r_frame    <= 1'b0;
    end else begin
      r_an  <= bus.AN;
      r_seg <= bus.SEG;

      if (w_chg || !w_an_ok) begin
        r_cnt <= '0;
      end else if (r_cnt != TOP) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_chg) begin
        r_captured <= 1'b0;
      end else if (w_cap) begin
        r_captured <= 1'b1;
      end

      if (w_cap) begin
        if (!w_bad) r_value[4*w_idx +: 4] <= w_nib;
        r_err[w_idx] <= w_bad;
        r_dp[w_idx]  <= r_seg[7];
        r_vld[w_idx] <= 1'b1;
      end

      // completing capture closes the frame; next frame starts empty
      if (&w_mask) begin
        r_mask  <= '0;
        r_frame <= 1'b1;
      end else begin
        r_mask  <= w_mask;
        r_frame <= 1'b0;
      end
    end
  end

  assign bus.VALUE       = r_value;
  assign bus.DP_OUT      = r_dp;
  assign bus.DIGIT_VALID = r_vld;
  assign bus.ERR         = r_err;
  assign bus.FRAME_DONE  = r_frame;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans plus random display traffic
// against a run-length based reference model.
module tb_seg7_scan_decoder;
  localparam int DIGITS = 4;
  localparam int SETTLE = 4;

  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;

  seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_decoder #(
    .DIGITS(DIGITS),
    .SETTLE(SETTLE)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [6:0] PAT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic [11:0] m_prev;
  int          m_run;
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  logic [3:0]  m_vld;
  logic [3:0]  m_err;
  logic [3:0]  m_mask;
  logic        m_frame;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_prev  = '0;
    m_run   = 0;
    m_value = '0;
    m_dp    = '0;
    m_vld   = '0;
    m_err   = '0;
    m_mask  = '0;
    m_frame = 1'b0;
  endtask

  function automatic int low_count(input logic [3:0] an);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) n++;
    return n;
  endfunction

  // one clock edge as seen by the model: capture on the edge where
  // the sampled value has been identical for SETTLE+1 edges
  task automatic m_edge(input logic [3:0] an, input logic [7:0] seg);
    logic [11:0] cur;
    int k;
    int nib;
    cur = {an, seg};
    if (cur == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev  = cur;
    m_frame = 1'b0;
    if (m_run == SETTLE + 1 && low_count(an) == 1) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (!an[i]) k = i;
      nib = -1;
      for (int p = 0; p < 10; p++) if (seg[6:0] == PAT[p]) nib = p;
      if (seg[6:0] == 7'h7F) nib = 15;
      if (nib >= 0) m_value[4*k +: 4] = nib[3:0];
      m_err[k] = (nib < 0);
      m_dp[k]  = seg[7];
      m_vld[k] = 1'b1;
      m_mask[k] = 1'b1;
      if (m_mask == 4'hF) begin
        m_frame = 1'b1;
        m_mask  = '0;
      end
    end
  endtask

  task automatic cmp_all();
    chk("value", 32'(bus.VALUE), 32'(m_value));
    chk("dp", 32'(bus.DP_OUT), 32'(m_dp));
    chk("valid", 32'(bus.DIGIT_VALID), 32'(m_vld));
    chk("err", 32'(bus.ERR), 32'(m_err));
    chk("frame", 32'(bus.FRAME_DONE), 32'(m_frame));
  endtask

  task automatic step();
    @(posedge CLK);
    m_edge(bus.AN, bus.SEG);
    #1;
    cmp_all();
  endtask

  task automatic hold(input logic [3:0] an, input logic [7:0] seg,
                      input int n);
    bus.AN  = an;
    bus.SEG = seg;
    for (int i = 0; i < n; i++) step();
  endtask

  int frames;

  initial begin
    checks = 0;
    errors = 0;
    frames = 0;
    RST_N   = 1'b0;
    bus.AN  = 4'hF;
    bus.SEG = 8'hFF;
    m_reset();
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_value", 32'(bus.VALUE), 32'h0);
    chk("rst_valid", 32'(bus.DIGIT_VALID), 32'h0);
    RST_N = 1'b1;

    hold(4'hF, 8'hFF, 10);

    // single digit: capture exactly SETTLE+1 edges after the change
    bus.AN  = 4'b1110;
    bus.SEG = 8'h40;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("lat_valid", 32'(bus.DIGIT_VALID),
          (i >= SETTLE + 1) ? 32'h1 : 32'h0);
    end

    hold(4'b1110, 8'h24, 6);
    hold(4'b1101, 8'h12, 6);
    hold(4'b1011, 8'h90, 6);
    bus.AN  = 4'b0111;
    bus.SEG = 8'h78;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.FRAME_DONE) frames++;
    end
    chk("scan_value", 32'(bus.VALUE), 32'h7952);
    chk("scan_dp", 32'(bus.DP_OUT), 32'h4);
    chk("scan_frames", 32'(frames), 32'd1);

    for (int i = 0; i < 4; i++) hold(4'b1101, (i % 2) ? 8'h24 : 8'h30, 3);
    chk("bounce_value", 32'(bus.VALUE[7:4]), 32'h5);
    hold(4'b1101, 8'h79, 6);
    chk("hold1_value", 32'(bus.VALUE[7:4]), 32'h1);

    hold(4'b1101, 8'h7F, 6);
    chk("blank_nib", 32'(bus.VALUE[7:4]), 32'hF);
    chk("blank_err", 32'(bus.ERR[1]), 32'h0);
    hold(4'b1101, 8'h55, 6);
    chk("bad_nib", 32'(bus.VALUE[7:4]), 32'hF);
    chk("bad_err", 32'(bus.ERR[1]), 32'h1);
    hold(4'b1100, 8'h40, 8);

    // async reset in the middle of a settle count
    hold(4'b1011, 8'h19, 3);
    #3;
    RST_N = 1'b0;
    #1;
    m_reset();
    chk("arst_value", 32'(bus.VALUE), 32'h0);
    chk("arst_valid", 32'(bus.DIGIT_VALID), 32'h0);
    chk("arst_err", 32'(bus.ERR), 32'h0);
    @(posedge CLK);
    #2;
    RST_N = 1'b1;
    for (int i = 1; i <= SETTLE + 2; i++) begin
      step();
      chk("arst_relat", 32'(bus.DIGIT_VALID),
          (i >= SETTLE + 1) ? 32'h4 : 32'h0);
    end

    // random display traffic
    for (int s = 0; s < 400; s++) begin
      logic [3:0] an;
      logic [7:0] seg;
      int pick;
      an = 4'hF;
      an[$urandom_range(0, 3)] = 1'b0;
      if ($urandom_range(0, 9) == 0) an = 4'($urandom);
      pick = $urandom_range(0, 9);
      if (pick <= 6) seg[6:0] = PAT[$urandom_range(0, 9)];
      else if (pick == 7) seg[6:0] = 7'h7F;
      else seg[6:0] = 7'($urandom);
      seg[7] = 1'($urandom);
      hold(an, seg, $urandom_range(1, 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
